// File: rtl/uart_tx_fifo_if.sv
// Handshake and line signals between the character producer and the
// FIFO-buffered UART transmitter. The producer uses the master modport and
// the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 i_Break;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Overflow;
  logic [CNT_W-1:0]     o_Fifo_Count;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Break,
    input  o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Break,
    output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with configurable frame format
// (data width, parity, stop bits) and line-break generation.
// Queued words go out back-to-back; the serial line is a registered
// function of the current state, so it lags the state by one cycle.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1155,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           osc_clk,
  input  logic           i_Rst_n,
  uart_tx_fifo_if.slave  tx
);

  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CLK_W      = $clog2(CLKS_PER_BIT);
  localparam int PAR_BITS   = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int IDX_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] BRK_LAST  = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] BRK_DONE  = IDX_W'(FRAME_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [DATA_BITS-1:0] pop_word;
  logic                 parity_calc;

  assign fifo_full   = (count_q == DEPTH_C);
  assign fifo_empty  = (count_q == '0);
  assign push        = tx.i_Tx_DV && !fifo_full;
  assign pop_word    = mem[rd_ptr_q];
  // Parity bit makes the total ones count of data+parity odd or even.
  assign parity_calc = (PARITY == 1) ? ~^pop_word : ^pop_word;

  // Pointer and occupancy update; a full FIFO drops the write and flags it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = tx.i_Tx_DV && fifo_full;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array write port.
  // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge osc_clk) begin
    if (push) mem[wr_ptr_q] <= tx.i_Tx_Byte;
  end

  // ----------------------------------------------------------- Line FSM
  state_e               state_q, state_d;
  logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 brk_req_q, brk_req_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bit_end, brk_pending, take;

  assign bit_end     = (clk_cnt_q == CLK_LAST);
  assign brk_pending = tx.i_Break || brk_req_q;

  // Next-state logic: bit timing, frame sequencing, break and mark handling.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + CLK_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    take      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (brk_pending) begin
          state_d   = S_BREAK;
          bit_idx_d = '0;
        end else if (!fifo_empty) begin
          take = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == DATA_LAST) begin
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            done_d = 1'b1;
            if (!brk_pending && !fifo_empty) take = 1'b1;
            else                             state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_BREAK: begin
        // bit_idx counts whole frame-length bit periods, then saturates
        // to mark that the minimum break length has been served.
        if (bit_idx_q == BRK_DONE) begin
          if (!tx.i_Break) begin
            state_d   = S_MARK;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end
        end else if (bit_end) begin
          if (bit_idx_q == BRK_LAST) begin
            if (!tx.i_Break) begin
              state_d   = S_MARK;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = BRK_DONE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_MARK: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            if (!brk_pending && !fifo_empty) take = 1'b1;
            else                             state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      pop       = 1'b1;
      state_d   = S_START;
      clk_cnt_d = '0;
      bit_idx_d = '0;
      shift_d   = pop_word;
      parity_d  = parity_calc;
    end
  end

  // Break requests seen mid-frame are remembered until the break starts.
  always_comb begin
    brk_req_d = (brk_req_q || tx.i_Break) && (state_d != S_BREAK);
  end

  // Registered line level and status derived from the current state.
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_q[0];
      S_PARITY: serial_d = parity_q;
      S_BREAK:  serial_d = 1'b0;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset returns the line high and empties the FIFO.
  always_ff @(posedge osc_clk or negedge i_Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      brk_req_q <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      brk_req_q <= brk_req_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign tx.o_Tx_Ready    = (count_q < DEPTH_C);
  assign tx.o_Tx_Overflow = ovf_q;
  assign tx.o_Fifo_Count  = count_q;
  assign tx.o_Tx_Active   = active_q;
  assign tx.o_Tx_Serial   = serial_q;
  assign tx.o_Tx_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: stimulus pushes expected frames and
// breaks into queues; an independent line monitor decodes o_Tx_Serial
// sample-by-sample and compares each decoded frame/break against them.
module tb_uart_tx_fifo;

  localparam int CLKS       = 4;
  localparam int DBITS      = 8;
  localparam int PAR        = 2;
  localparam int STOPB      = 1;
  localparam int DEPTH      = 4;
  localparam int FRAME_BITS = 1 + DBITS + ((PAR != 0) ? 1 : 0) + STOPB;
  localparam int FRAME_CYC  = FRAME_BITS * CLKS;

  typedef struct {
    logic [DBITS-1:0] data;
    logic             par;
    int               gap;   // required idle cycles before this frame, -1 = any
  } frame_t;

  typedef struct {
    int low;                 // required low cycles
    int mark;                // required high cycles after, 0 = at least the mark time
  } brk_t;

  logic osc_clk = 1'b0;
  logic i_Rst_n = 1'b0;

  uart_tx_fifo_if #(.DATA_BITS(DBITS), .FIFO_DEPTH(DEPTH)) tx_if ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(DBITS), .PARITY(PAR),
    .STOP_BITS(STOPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .osc_clk (osc_clk),
    .i_Rst_n (i_Rst_n),
    .tx      (tx_if)
  );

  always #5 osc_clk = ~osc_clk;

  int checks = 0;
  int errors = 0;

  frame_t exp_q[$];
  brk_t   brk_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic ref_parity(input logic [DBITS-1:0] d);
    int ones = $countones(d);
    if (PAR == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  // ---------------------------------------------------------- event counters
  int done_cnt = 0;
  int ovf_cnt  = 0;

  always @(negedge osc_clk) begin
    if (i_Rst_n && tx_if.o_Tx_Done)     done_cnt++;
    if (i_Rst_n && tx_if.o_Tx_Overflow) ovf_cnt++;
  end

  // ------------------------------------------------------------ line monitor
  int   mon_phase = 0;   // 0 line watch, 1 capturing a frame window, 2 in break
  int   cap_idx = 0;
  int   high_run = 0;
  int   low_run = 0;
  int   start_gap = -1;
  int   mark_exp = 0;
  bit   mark_pending = 1'b0;
  int   frames_seen = 0;
  logic cap [FRAME_CYC];

  task automatic finish_capture();
    bit               all_zero = 1'b1;
    bit               stable = 1'b1;
    bit               stop_ok = 1'b1;
    logic [DBITS-1:0] d;
    frame_t           e;
    for (int i = 0; i < FRAME_CYC; i++) if (cap[i] !== 1'b0) all_zero = 1'b0;
    if (all_zero) begin
      mon_phase = 2;
      low_run   = FRAME_CYC;
      return;
    end
    for (int b = 0; b < FRAME_BITS; b++)
      for (int s = 1; s < CLKS; s++)
        if (cap[b*CLKS + s] !== cap[b*CLKS]) stable = 1'b0;
    for (int b = 0; b < DBITS; b++) d[b] = cap[(1 + b) * CLKS];
    for (int b = FRAME_BITS - STOPB; b < FRAME_BITS; b++)
      if (cap[b*CLKS] !== 1'b1) stop_ok = 1'b0;
    check("bit_duration", stable, 1);
    check("stop_bits", stop_ok, 1);
    check("frame_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("frame_data", d, e.data);
      if (PAR != 0) check("frame_parity", cap[(1 + DBITS) * CLKS], e.par);
      if (e.gap >= 0) check("frame_gap", start_gap, e.gap);
    end
    frames_seen++;
    mon_phase = 0;
    high_run  = 0;
  endtask

  always @(negedge osc_clk) begin
    if (!i_Rst_n) begin
      mon_phase    = 0;
      high_run     = 0;
      mark_pending = 1'b0;
    end else begin
      case (mon_phase)
        0: begin
          if (tx_if.o_Tx_Serial === 1'b1) begin
            high_run++;
          end else begin
            if (mark_pending) begin
              if (mark_exp > 0) check("mark_len", high_run, mark_exp);
              else              check("mark_min", high_run >= STOPB * CLKS, 1);
              mark_pending = 1'b0;
              start_gap    = -1;
            end else begin
              start_gap = high_run;
            end
            cap[0]    = 1'b0;
            cap_idx   = 1;
            mon_phase = 1;
          end
        end
        1: begin
          cap[cap_idx] = tx_if.o_Tx_Serial;
          cap_idx++;
          if (cap_idx == FRAME_CYC) finish_capture();
        end
        default: begin
          if (tx_if.o_Tx_Serial === 1'b0) begin
            low_run++;
          end else begin
            brk_t b;
            check("break_expected", brk_q.size() != 0, 1);
            if (brk_q.size() != 0) begin
              b = brk_q.pop_front();
              check("break_len", low_run, b.low);
              mark_exp = b.mark;
            end else begin
              mark_exp = 0;
            end
            mark_pending = 1'b1;
            high_run     = 1;
            mon_phase    = 0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge osc_clk);
    #1;
  endtask

  task automatic write_word(input logic [DBITS-1:0] d, input int gap);
    frame_t e;
    e.data = d; e.par = ref_parity(d); e.gap = gap;
    exp_q.push_back(e);
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Byte = d;
    tick(1);
    tx_if.i_Tx_DV   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || brk_q.size() != 0 || tx_if.o_Tx_Active === 1'b1
            || mon_phase != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_drain_in_time"}, n < budget, 1);
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, f0;
    logic [DBITS-1:0] burst [6];
    brk_t b;

    tx_if.i_Tx_DV   = 1'b0;
    tx_if.i_Tx_Byte = '0;
    tx_if.i_Break   = 1'b0;

    // Reset state
    tick(3);
    check("rst_serial", tx_if.o_Tx_Serial, 1);
    check("rst_active", tx_if.o_Tx_Active, 0);
    check("rst_done", tx_if.o_Tx_Done, 0);
    check("rst_overflow", tx_if.o_Tx_Overflow, 0);
    check("rst_count", tx_if.o_Fifo_Count, 0);
    check("rst_ready", tx_if.o_Tx_Ready, 1);
    i_Rst_n = 1'b1;
    tick(2);

    // Single word from an idle, empty FIFO: start bit after the second edge
    d0 = done_cnt;
    write_word(8'hA5, -1);
    check("lat_edge_n_serial", tx_if.o_Tx_Serial, 1);
    check("lat_edge_n_active", tx_if.o_Tx_Active, 0);
    tick(1);
    check("lat_edge_n1_serial", tx_if.o_Tx_Serial, 1);
    check("lat_edge_n1_active", tx_if.o_Tx_Active, 1);
    check("lat_edge_n1_count", tx_if.o_Fifo_Count, 0);
    tick(1);
    check("lat_edge_n2_serial", tx_if.o_Tx_Serial, 0);
    wait_drain("single", 200);
    check("single_done_pulses", done_cnt - d0, 1);

    // Six back-to-back writes into a 4-deep FIFO while idle
    d0 = done_cnt; o0 = ovf_cnt;
    burst = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E, 8'h55};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        frame_t e;
        e.data = burst[i]; e.par = ref_parity(burst[i]); e.gap = (i == 0) ? -1 : 0;
        exp_q.push_back(e);
      end
      tx_if.i_Tx_DV   = 1'b1;
      tx_if.i_Tx_Byte = burst[i];
      tick(1);
    end
    tx_if.i_Tx_DV = 1'b0;
    check("burst_count_full", tx_if.o_Fifo_Count, DEPTH);
    check("burst_ready_low", tx_if.o_Tx_Ready, 0);
    wait_drain("burst", 6 * FRAME_CYC + 100);
    check("burst_overflow_pulses", ovf_cnt - o0, 1);
    check("burst_done_pulses", done_cnt - d0, 5);
    check("burst_count_empty", tx_if.o_Fifo_Count, 0);
    check("burst_ready_high", tx_if.o_Tx_Ready, 1);

    // Short break request mid-frame: frame completes, then a minimum-length break
    d0 = done_cnt;
    write_word(8'h3C, -1);
    tick(20);
    b.low = FRAME_CYC; b.mark = STOPB * CLKS;
    brk_q.push_back(b);
    tx_if.i_Break = 1'b1;
    tick(3);
    tx_if.i_Break = 1'b0;
    tick(30);
    check("break_active", tx_if.o_Tx_Active, 1);
    check("break_line_low", tx_if.o_Tx_Serial, 0);
    write_word(8'h5A, -1);
    wait_drain("break", 400);
    check("break_done_pulses", done_cnt - d0, 2);

    // Randomized traffic; the producer only writes while o_Tx_Ready is high
    o0 = ovf_cnt;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && tx_if.o_Tx_Ready === 1'b1)
        write_word(DBITS'($urandom), -1);
      else
        tick(1);
    end
    wait_drain("random", 2 * DEPTH * FRAME_CYC + 200);
    check("random_no_overflow", ovf_cnt - o0, 0);
    check("random_count_empty", tx_if.o_Fifo_Count, 0);

    // Asynchronous reset in the middle of a data bit with three words queued
    write_word(8'h00, -1);
    write_word(8'h11, -1);
    write_word(8'h22, -1);
    write_word(8'h33, -1);
    tick(8);
    check("pre_rst_line_low", tx_if.o_Tx_Serial, 0);
    check("pre_rst_count", tx_if.o_Fifo_Count, 3);
    #2;
    i_Rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_serial", tx_if.o_Tx_Serial, 1);
    check("async_rst_count", tx_if.o_Fifo_Count, 0);
    check("async_rst_ready", tx_if.o_Tx_Ready, 1);
    check("async_rst_active", tx_if.o_Tx_Active, 0);
    tick(2);
    i_Rst_n = 1'b1;
    d0 = done_cnt; f0 = frames_seen;
    tick(150);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("post_rst_no_frames", frames_seen - f0, 0);
    check("post_rst_serial_idle", tx_if.o_Tx_Serial, 1);
    check("post_rst_count", tx_if.o_Fifo_Count, 0);

    check("done_matches_frames", done_cnt, frames_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
